// File: rtl/alu_md_pkg.sv
// Shared definitions for the alu_md execute stage: MIPS funct codes and
// the mul/div sequencer state encoding.
package alu_pkg;

  localparam logic [5:0] F_SLL   = 6'b000000;
  localparam logic [5:0] F_SRL   = 6'b000010;
  localparam logic [5:0] F_SRA   = 6'b000011;
  localparam logic [5:0] F_BEQ   = 6'b000100;
  localparam logic [5:0] F_BNE   = 6'b000101;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_XOR   = 6'b100110;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLTU  = 6'b101011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  function automatic logic is_muldiv(input logic [5:0] funct);
    return (funct == F_MULT) || (funct == F_MULTU) ||
           (funct == F_DIV)  || (funct == F_DIVU);
  endfunction

endpackage

// File: rtl/alu_md_muldiv_seq.sv
// Iterative shift-add multiplier / restoring divider working on operand
// magnitudes, with the sign correction applied to the results in FIX.
//
// state | meaning
// IDLE  | waiting for start; operands latched on start
// RUN   | one product/quotient bit per cycle, counter WIDTH-1 down to 0
// FIX   | signed results presented on hi_out/lo_out, done high
module muldiv_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam int CW = $clog2(WIDTH);

  state_t r_state;
  state_t w_state_nxt;

  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [WIDTH-1:0]   r_b;
  logic               r_div;
  logic               r_neg_q;
  logic               r_neg_r;

  logic               w_signed;
  logic               w_sa;
  logic               w_sb;
  logic               w_dz;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_diff;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_fix;

  // op[1] selects divide, op[0] selects unsigned
  assign w_signed = ~op[0];
  assign w_sa     = w_signed & op_a[WIDTH-1];
  assign w_sb     = w_signed & op_b[WIDTH-1];
  assign w_dz     = op[1] & (op_b == '0);
  assign w_mag_a  = w_sa ? -op_a : op_a;
  assign w_mag_b  = w_sb ? -op_b : op_b;

  assign w_sum   = {1'b0, r_hi} + ({1'b0, r_b} & {(WIDTH+1){r_lo[0]}});
  assign w_shift = {r_hi, r_lo[WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, r_b};

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = RUN;
      RUN:     if (r_cnt == '0) w_state_nxt = FIX;
      FIX:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_b     <= '0;
      r_div   <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_cnt   <= CW'(WIDTH-1);
            r_hi    <= '0;
            r_lo    <= w_mag_a;
            r_b     <= w_mag_b;
            r_div   <= op[1];
            // a zero divisor leaves the all-ones quotient uncorrected
            r_neg_q <= (w_sa ^ w_sb) & ~w_dz;
            r_neg_r <= op[1] & w_sa;
          end
        end
        RUN: begin
          r_cnt <= r_cnt - CW'(1);
          if (r_div) begin
            r_lo <= {r_lo[WIDTH-2:0], ~w_diff[WIDTH]};
            r_hi <= w_diff[WIDTH] ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
          end else begin
            {r_hi, r_lo} <= {w_sum, r_lo[WIDTH-1:1]};
          end
        end
        default: ;
      endcase
    end
  end

  assign w_prod     = {r_hi, r_lo};
  assign w_prod_fix = r_neg_q ? -w_prod : w_prod;

  assign busy   = (r_state != IDLE);
  assign done   = (r_state == FIX);
  assign hi_out = r_div ? (r_neg_r ? -r_hi : r_hi) : w_prod_fix[2*WIDTH-1:WIDTH];
  assign lo_out = r_div ? (r_neg_q ? -r_lo : r_lo) : w_prod_fix[WIDTH-1:0];

endmodule

// File: rtl/alu_md.sv
// MIPS execute-stage ALU: single-cycle R-type ops plus an iterative
// mul/div unit feeding the architectural HI/LO registers.
module alu_md
  import alu_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  input  logic [5:0]       alu_op,
  input  logic [SHW-1:0]   shamt,
  output logic             out_valid,
  output logic [WIDTH-1:0] alu_res,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic             r_out_valid;
  logic [WIDTH-1:0] r_alu_res;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic             w_accept;
  logic             w_is_md;
  logic             w_start;
  logic             w_single;
  logic             w_busy;
  logic             w_done;
  logic [WIDTH-1:0] w_md_hi;
  logic [WIDTH-1:0] w_md_lo;
  logic [WIDTH-1:0] w_res;

  assign w_is_md  = is_muldiv(alu_op);
  assign w_accept = in_valid & in_ready;
  assign w_start  = w_accept & w_is_md;
  assign w_single = w_accept & ~w_is_md;
  assign in_ready = ~w_busy;

  muldiv_seq #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (clk),
    .nrst   (nrst),
    .start  (w_start),
    .op     (alu_op[1:0]),
    .op_a   (opA),
    .op_b   (opB),
    .busy   (w_busy),
    .done   (w_done),
    .hi_out (w_md_hi),
    .lo_out (w_md_lo)
  );

  always_comb begin
    w_res = '0;
    case (alu_op)
      F_ADD:  w_res = opA + opB;
      F_SUB:  w_res = opA - opB;
      F_AND:  w_res = opA & opB;
      F_OR:   w_res = opA | opB;
      F_XOR:  w_res = opA ^ opB;
      F_NOR:  w_res = ~(opA | opB);
      F_SLT:  w_res[0] = $signed(opA) < $signed(opB);
      F_SLTU: w_res[0] = opA < opB;
      F_SLL:  w_res = opB << shamt;
      F_SRL:  w_res = opB >> shamt;
      F_SRA:  w_res = $signed(opB) >>> shamt;
      F_BEQ:  w_res[0] = (opA == opB);
      F_BNE:  w_res[0] = (opA != opB);
      F_MFHI: w_res = r_hi;
      F_MFLO: w_res = r_lo;
      default: w_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_out_valid <= 1'b0;
      r_alu_res   <= '0;
      r_hi        <= '0;
      r_lo        <= '0;
    end else begin
      r_out_valid <= w_single | w_done;
      if (w_single)    r_alu_res <= w_res;
      else if (w_done) r_alu_res <= '0;
      if (w_done) begin
        r_hi <= w_md_hi;
        r_lo <= w_md_lo;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign alu_res   = r_alu_res;
  assign hi        = r_hi;
  assign lo        = r_lo;

endmodule

// File: tb/tb_alu_md.sv
// Directed self-checking bench for alu_md (WIDTH=32 and WIDTH=8 instances).
module tb_alu_md;

  localparam logic [5:0] C_SLL   = 6'b000000;
  localparam logic [5:0] C_SRL   = 6'b000010;
  localparam logic [5:0] C_SRA   = 6'b000011;
  localparam logic [5:0] C_BEQ   = 6'b000100;
  localparam logic [5:0] C_BNE   = 6'b000101;
  localparam logic [5:0] C_MFHI  = 6'b010000;
  localparam logic [5:0] C_MFLO  = 6'b010010;
  localparam logic [5:0] C_MULT  = 6'b011000;
  localparam logic [5:0] C_MULTU = 6'b011001;
  localparam logic [5:0] C_DIV   = 6'b011010;
  localparam logic [5:0] C_DIVU  = 6'b011011;
  localparam logic [5:0] C_ADD   = 6'b100000;
  localparam logic [5:0] C_SUB   = 6'b100010;
  localparam logic [5:0] C_AND   = 6'b100100;
  localparam logic [5:0] C_OR    = 6'b100101;
  localparam logic [5:0] C_XOR   = 6'b100110;
  localparam logic [5:0] C_NOR   = 6'b100111;
  localparam logic [5:0] C_SLT   = 6'b101010;
  localparam logic [5:0] C_SLTU  = 6'b101011;

  logic        clk = 1'b0;
  logic        nrst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] opA, opB;
  logic [5:0]  alu_op;
  logic [4:0]  shamt;
  logic        out_valid;
  logic [31:0] alu_res, hi, lo;

  logic        in_valid8;
  logic        in_ready8;
  logic [7:0]  opA8, opB8;
  logic [5:0]  alu_op8;
  logic [2:0]  shamt8;
  logic        out_valid8;
  logic [7:0]  alu_res8, hi8, lo8;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_md #(.WIDTH(32)) dut (
    .clk(clk), .nrst(nrst), .in_valid(in_valid), .in_ready(in_ready),
    .opA(opA), .opB(opB), .alu_op(alu_op), .shamt(shamt),
    .out_valid(out_valid), .alu_res(alu_res), .hi(hi), .lo(lo)
  );

  alu_md #(.WIDTH(8)) dut8 (
    .clk(clk), .nrst(nrst), .in_valid(in_valid8), .in_ready(in_ready8),
    .opA(opA8), .opB(opB8), .alu_op(alu_op8), .shamt(shamt8),
    .out_valid(out_valid8), .alu_res(alu_res8), .hi(hi8), .lo(lo8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // present a single-cycle op; result checked in the following cycle
  task automatic sop(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] sh, input logic [31:0] exp, input string tag);
    alu_op = op; opA = a; opB = b; shamt = sh; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
    chk(tag, alu_res, exp);
  endtask

  task automatic md(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                    input logic [31:0] exp_hi, input logic [31:0] exp_lo, input string tag);
    int lat;
    bit busy_ok;
    alu_op = op; opA = a; opB = b; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    opA = 32'h1234_5678;
    opB = 32'h0000_0003;
    lat = 1;
    busy_ok = 1'b1;
    while (out_valid !== 1'b1 && lat < 40) begin
      if (in_ready !== 1'b0) busy_ok = 1'b0;
      tick();
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'd34);
    chk({tag, "_busy"}, {31'b0, busy_ok}, 32'd1);
    chk({tag, "_hi"}, hi, exp_hi);
    chk({tag, "_lo"}, lo, exp_lo);
    chk({tag, "_res"}, alu_res, 32'd0);
    chk({tag, "_ready"}, {31'b0, in_ready}, 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int lat8;
    bit seen;
    nrst = 1'b0; in_valid = 1'b0; opA = '0; opB = '0; alu_op = '0; shamt = '0;
    in_valid8 = 1'b0; opA8 = '0; opB8 = '0; alu_op8 = '0; shamt8 = '0;
    #3;
    chk("rst_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_res", alu_res, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    tick();
    nrst = 1'b1;
    tick();

    sop(C_ADD, 32'd5, 32'd7, 5'd0, 32'h0000_000C, "add");
    sop(C_SUB, 32'd5, 32'd7, 5'd0, 32'hFFFF_FFFE, "sub");
    sop(C_SLT, 32'h7FFF_FFFF, 32'h8000_0000, 5'd0, 32'd0, "slt_pos_neg");
    sop(C_SLT, 32'h8000_0000, 32'h7FFF_FFFF, 5'd0, 32'd1, "slt_neg_pos");
    sop(C_SLTU, 32'h8000_0000, 32'h7FFF_FFFF, 5'd0, 32'd0, "sltu");
    sop(C_SRA, 32'd0, 32'h8000_0000, 5'd4, 32'hF800_0000, "sra");
    sop(C_SRL, 32'd0, 32'h8000_0000, 5'd4, 32'h0800_0000, "srl");
    sop(C_SLL, 32'd0, 32'h0000_0001, 5'd31, 32'h8000_0000, "sll");
    sop(C_AND, 32'h0000_F0F0, 32'h0000_0FF0, 5'd0, 32'h0000_00F0, "and");
    sop(C_OR,  32'h0000_F0F0, 32'h0000_0FF0, 5'd0, 32'h0000_FFF0, "or");
    sop(C_XOR, 32'h0000_F0F0, 32'h0000_0FF0, 5'd0, 32'h0000_FF00, "xor");
    sop(C_NOR, 32'd0, 32'd0, 5'd0, 32'hFFFF_FFFF, "nor");
    sop(C_BEQ, 32'd5, 32'd5, 5'd0, 32'd1, "beq");
    sop(C_BNE, 32'd5, 32'd5, 5'd0, 32'd0, "bne");
    sop(C_ADD, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'd0, "add_wrap");
    sop(C_ADD, 32'd9, 32'd9, 5'd0, 32'd18, "add_pre_undef");
    sop(6'b111111, 32'd5, 32'd7, 5'd0, 32'd0, "undef");
    tick();
    chk("single_pulse", {31'b0, out_valid}, 32'd0);

    md(C_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult");
    sop(C_MFHI, 32'd0, 32'd0, 5'd0, 32'hFFFF_FFFF, "mfhi");
    sop(C_MFLO, 32'd0, 32'd0, 5'd0, 32'hFFFF_FFEB, "mflo");
    md(C_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu");
    tick();
    chk("md_pulse", {31'b0, out_valid}, 32'd0);
    md(C_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, "divu");
    md(C_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg");
    md(C_DIV, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, "div_zero");
    md(C_DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, "div_zero_neg");

    sop(C_ADD, 32'd3, 32'd4, 5'd0, 32'd7, "add_pre_rst");
    alu_op = C_MULT; opA = 32'd3; opB = 32'd5; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (9) tick();
    nrst = 1'b0;
    #1;
    chk("rst_mid_hi", hi, 32'd0);
    chk("rst_mid_lo", lo, 32'd0);
    chk("rst_mid_res", alu_res, 32'd0);
    chk("rst_mid_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_mid_valid", {31'b0, out_valid}, 32'd0);
    seen = 1'b0;
    repeat (3) begin
      tick();
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    nrst = 1'b1;
    repeat (40) begin
      tick();
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    chk("rst_no_valid", {31'b0, seen}, 32'd0);
    sop(C_ADD, 32'd1, 32'd1, 5'd0, 32'd2, "add_after_rst");

    alu_op8 = C_MULTU; opA8 = 8'hFF; opB8 = 8'hFF; in_valid8 = 1'b1;
    tick();
    in_valid8 = 1'b0;
    lat8 = 1;
    while (out_valid8 !== 1'b1 && lat8 < 20) begin
      tick();
      lat8++;
    end
    chk("w8_multu_latency", 32'(lat8), 32'd10);
    chk("w8_multu_hi", {24'b0, hi8}, 32'h0000_00FE);
    chk("w8_multu_lo", {24'b0, lo8}, 32'h0000_0001);

    alu_op8 = C_DIV; opA8 = 8'h80; opB8 = 8'hFF; in_valid8 = 1'b1;
    tick();
    in_valid8 = 1'b0;
    lat8 = 1;
    while (out_valid8 !== 1'b1 && lat8 < 20) begin
      tick();
      lat8++;
    end
    chk("w8_div_latency", 32'(lat8), 32'd10);
    chk("w8_div_hi", {24'b0, hi8}, 32'h0000_0000);
    chk("w8_div_lo", {24'b0, lo8}, 32'h0000_0080);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
